ethgen_burst_scheduler: RTL and testbench
=========================================

Name: ethgen_burst_scheduler

Overview:
- Sequences data_generator into repeated bursts of packets, with a programmable idle gap between bursts.
- Drives the generator's start/packet_count inputs and snoops its AXIS TX handshake (TVALID/TREADY/TLAST) to count completed packets.
- Supports finite or infinite burst counts, a clean stop at a packet boundary, and status counters for software.

Parameters:
- STOP_SETTLE, 3, cycles to wait after a stop pulse before sampling generator TVALID. Covers the generator's 2-cycle start→TVALID path.
- GAP_W, 32, width of the inter-burst gap counter.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- cfg_packets_per_burst  in  64  packets per burst; sampled on cmd_start
- cfg_burst_count  in  32  bursts to run; 0 = infinite; sampled on cmd_start
- cfg_gap_cycles  in  GAP_W  idle cycles between bursts; sampled on cmd_start
- cmd_start  in  1  single-cycle start request
- cmd_stop  in  1  single-cycle stop request
- gen_start  out  1  single-cycle pulse to the generator's start input
- gen_packet_count  out  64  to the generator's packet_count input
- snoop_tvalid  in  1  generator AXIS_TX_TVALID
- snoop_tready  in  1  sink AXIS_TX_TREADY
- snoop_tlast  in  1  generator AXIS_TX_TLAST
- busy  out  1  high in any state other than IDLE
- done  out  1  single-cycle pulse when a run ends, whether by completion or by stop
- cfg_error  out  1  set when cmd_start arrives with cfg_packets_per_burst==0; cleared by the next accepted cmd_start
- bursts_done  out  32  bursts completed in the current run
- packets_sent  out  64  packets completed in the current run; wraps modulo 2^64

Behaviour:
- Reset (async, resetn=0): FSM→IDLE. All outputs 0: gen_start, gen_packet_count, busy, done, cfg_error, bursts_done, packets_sent.
- Registered outputs; no combinational path from inputs to outputs.
- Packet completion event: pkt_end = snoop_tvalid & snoop_tready & snoop_tlast.

FSM states: IDLE, LAUNCH, RUN, GAP, STOP_WAIT.

- IDLE:
  - On cmd_start with cmd_stop=0:
    - If cfg_packets_per_burst==0: cfg_error←1, remain IDLE.
    - Otherwise: latch all three cfg inputs; clear bursts_done, packets_sent and cfg_error; →LAUNCH.
  - cmd_stop in IDLE has no effect.
- LAUNCH (exactly 1 cycle):
  - gen_start=1 and gen_packet_count=latched packets_per_burst on this cycle; clear the burst packet counter; →RUN.
  - A cmd_stop during LAUNCH sets stop_pending, which is acted on in the first RUN cycle.
- RUN:
  - Each pkt_end increments packets_sent and the burst packet counter.
  - When the pkt_end that brings the burst counter to packets_per_burst occurs: bursts_done+1.
    - If burst_count≠0 and the new bursts_done==burst_count: done=1, →IDLE.
    - Else if gap==0: →LAUNCH.
    - Else: load the gap timer with gap_cycles, →GAP.
  - RUN never exits on TVALID low; exit is count-based only.
- GAP: the timer decrements each cycle; →LAUNCH on the cycle it reaches 1, giving exactly gap_cycles idle cycles between RUN exit and LAUNCH.
- Stop:
  - From GAP: →IDLE immediately, done=1.
  - From RUN, or with stop_pending set: emit gen_start=1 with gen_packet_count=0, so the generator ends at its current packet boundary and stays idle. Then →STOP_WAIT.
- STOP_WAIT:
  - Hold for STOP_SETTLE cycles, then wait for snoop_tvalid==0, then done=1, →IDLE.
  - pkt_end during STOP_WAIT still increments packets_sent.
  - bursts_done does not increment unless the final pkt_end completes the burst.
- Simultaneous events:
  - cmd_start and cmd_stop in IDLE: stop wins, start is ignored.
  - cmd_start while busy: ignored.
  - cmd_stop coinciding with the burst-completing pkt_end: counters update first, then the stop path is taken (run ends; no further LAUNCH).
- Reset mid-run: the scheduler clears asynchronously. The generator has its own synchronous reset; system reset drives both.

Decomposition:
- Shared package ethgen_pkg:
  - FSM state enum (IDLE, LAUNCH, RUN, GAP, STOP_WAIT).
  - STOP_SETTLE default.
  - Packet count width constant (64).
- One sub-module, ethgen_gap_timer: load/decrement/expire counter of width GAP_W with a 1-cycle expire pulse. Reused later for rate pacing.

Test Plan:
- packets=3, bursts=2, gap=10, sink always ready, generator attached → two gen_start pulses with count 3, 10 idle cycles between RUN exit and second LAUNCH; final packets_sent=6, bursts_done=2, one done pulse, busy=0.
- packets=1, bursts=0 (infinite), gap=0; cmd_stop after 5 packets → second gen_start with count 0; TLAST-terminated packet boundary respected; packets_sent=5 or 6 matching TLAST handshakes observed; done once.
- packets=0 at cmd_start → cfg_error=1, busy stays 0, no gen_start; next start with packets=2 clears cfg_error.
- cmd_stop during GAP (gap=100) → IDLE next cycle, done=1, no gen_start with count 0 emitted.
- TREADY toggled 50% random during packets=4, bursts=3 → packets_sent=12, bursts_done=3; cmd_start pulses while busy are ignored (no extra gen_start).
- resetn asserted mid-RUN → all outputs 0 immediately (asynchronous); after release, a fresh cmd_start runs normally from zeroed counters.

Source files
------------

// File: rtl/ethgen_pkg.sv
// Shared types and constants for the ethgen burst scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ethgen_pkg;

  // Width of every packet-count quantity exchanged with the generator.
  localparam int PKT_CNT_W = 64;

  // Cycles to hold after a stop launch before trusting generator TVALID;
  // the generator needs 2 cycles from start to TVALID, plus one of margin.
  localparam int STOP_SETTLE_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_GAP,
    ST_STOP_WAIT
  } sched_state_t;

endpackage

// File: rtl/ethgen_gap_timer.sv
// Load/decrement countdown that pulses o_expire for one cycle when it reads 1.
// Latency: loaded value N gives the expire pulse N cycles after the load edge.
// Backpressure: none; free-running once loaded, i_clr abandons a countdown.
module ethgen_gap_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_clr,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  // Count down towards zero; a load takes priority over a clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // Reading 1 means this is the last counted cycle.
  assign o_expire = (r_cnt == W'(1));

endmodule

// File: rtl/ethgen_burst_scheduler.sv
// Sequences the packet generator into bursts separated by programmable idle gaps.
// Latency: cmd_start -> gen_start 1 cycle; burst-ending TLAST -> next gen_start gap+1 cycles.
// Backpressure: passive snoop of the TX handshake; stop waits for generator TVALID to drop.
module ethgen_burst_scheduler
  import ethgen_pkg::*;
#(
  parameter int STOP_SETTLE = STOP_SETTLE_DEF,
  parameter int GAP_W       = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [PKT_CNT_W-1:0] cfg_packets_per_burst,
  input  logic [31:0]          cfg_burst_count,
  input  logic [GAP_W-1:0]     cfg_gap_cycles,
  input  logic                 cmd_start,
  input  logic                 cmd_stop,
  output logic                 gen_start,
  output logic [PKT_CNT_W-1:0] gen_packet_count,
  input  logic                 snoop_tvalid,
  input  logic                 snoop_tready,
  input  logic                 snoop_tlast,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_error,
  output logic [31:0]          bursts_done,
  output logic [PKT_CNT_W-1:0] packets_sent
);

  localparam int SETTLE_W = (STOP_SETTLE < 1) ? 1 : $clog2(STOP_SETTLE + 1);

  sched_state_t         r_state;
  logic [PKT_CNT_W-1:0] r_ppb;
  logic [31:0]          r_burst_count;
  logic [GAP_W-1:0]     r_gap;
  logic [PKT_CNT_W-1:0] r_burst_pkts;
  logic                 r_stop_pending;
  logic [SETTLE_W-1:0]  r_settle;
  logic                 r_gen_start;
  logic [PKT_CNT_W-1:0] r_gen_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_cfg_error;
  logic [31:0]          r_bursts_done;
  logic [PKT_CNT_W-1:0] r_packets_sent;

  logic                 w_pkt_end;
  logic                 w_cnt_evt;
  logic [PKT_CNT_W-1:0] w_burst_pkts_nxt;
  logic                 w_burst_end;
  logic [31:0]          w_bursts_nxt;
  logic                 w_run_end;
  logic                 w_stop_req;
  logic                 w_tmr_load;
  logic                 w_tmr_clr;
  logic                 w_tmr_expire;

  assign w_pkt_end        = snoop_tvalid & snoop_tready & snoop_tlast;
  // Packets only count while a burst is live or draining after a stop.
  assign w_cnt_evt        = w_pkt_end & ((r_state == ST_RUN) | (r_state == ST_STOP_WAIT));
  assign w_burst_pkts_nxt = r_burst_pkts + 64'd1;
  assign w_burst_end      = w_cnt_evt & (w_burst_pkts_nxt == r_ppb);
  assign w_bursts_nxt     = r_bursts_done + 32'd1;
  assign w_run_end        = w_burst_end & (r_burst_count != 32'd0) & (w_bursts_nxt == r_burst_count);
  assign w_stop_req       = cmd_stop | r_stop_pending;
  assign w_tmr_load       = (r_state == ST_RUN) & w_burst_end & ~w_run_end & ~w_stop_req &
                            (r_gap != '0);
  assign w_tmr_clr        = (r_state == ST_GAP) & cmd_stop;

  ethgen_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .resetn     (resetn),
    .i_load     (w_tmr_load),
    .i_load_val (r_gap),
    .i_clr      (w_tmr_clr),
    .o_expire   (w_tmr_expire)
  );

  // Scheduler FSM with status counters; every output is registered here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_ppb          <= '0;
      r_burst_count  <= '0;
      r_gap          <= '0;
      r_burst_pkts   <= '0;
      r_stop_pending <= 1'b0;
      r_settle       <= '0;
      r_gen_start    <= 1'b0;
      r_gen_cnt      <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_cfg_error    <= 1'b0;
      r_bursts_done  <= '0;
      r_packets_sent <= '0;
    end else begin
      r_gen_start <= 1'b0;
      r_done      <= 1'b0;

      // Counters update before any state decision so a coincident stop sees them.
      if (w_cnt_evt) begin
        r_packets_sent <= r_packets_sent + 64'd1;
        r_burst_pkts   <= w_burst_pkts_nxt;
        if (w_burst_end) begin
          r_bursts_done <= w_bursts_nxt;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (cmd_start && !cmd_stop) begin
            if (cfg_packets_per_burst == '0) begin
              r_cfg_error <= 1'b1;
            end else begin
              r_ppb          <= cfg_packets_per_burst;
              r_burst_count  <= cfg_burst_count;
              r_gap          <= cfg_gap_cycles;
              r_bursts_done  <= '0;
              r_packets_sent <= '0;
              r_cfg_error    <= 1'b0;
              r_stop_pending <= 1'b0;
              r_gen_start    <= 1'b1;
              r_gen_cnt      <= cfg_packets_per_burst;
              r_busy         <= 1'b1;
              r_state        <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          r_burst_pkts <= '0;
          if (cmd_stop) begin
            r_stop_pending <= 1'b1;
          end
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_run_end) begin
            r_stop_pending <= 1'b0;
            r_done         <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= ST_IDLE;
          end else if (w_stop_req) begin
            // A zero-count start makes the generator finish its current packet and idle.
            r_stop_pending <= 1'b0;
            r_gen_start    <= 1'b1;
            r_gen_cnt      <= '0;
            r_settle       <= SETTLE_W'(STOP_SETTLE);
            r_state        <= ST_STOP_WAIT;
          end else if (w_burst_end) begin
            if (r_gap == '0) begin
              r_gen_start <= 1'b1;
              r_gen_cnt   <= r_ppb;
              r_state     <= ST_LAUNCH;
            end else begin
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (cmd_stop) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_tmr_expire) begin
            r_gen_start <= 1'b1;
            r_gen_cnt   <= r_ppb;
            r_state     <= ST_LAUNCH;
          end
        end
        ST_STOP_WAIT: begin
          if (r_settle != '0) begin
            r_settle <= r_settle - SETTLE_W'(1);
          end else if (!snoop_tvalid) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign gen_start        = r_gen_start;
  assign gen_packet_count = r_gen_cnt;
  assign busy             = r_busy;
  assign done             = r_done;
  assign cfg_error        = r_cfg_error;
  assign bursts_done      = r_bursts_done;
  assign packets_sent     = r_packets_sent;

endmodule

// File: tb/tb_ethgen_burst_scheduler.sv
// Directed bench for ethgen_burst_scheduler with a small behavioural generator.
// The generator starts TVALID 2 cycles after a start and sends 2-beat packets.
// A zero-count start makes it finish the packet in flight and go idle.
module tb_ethgen_burst_scheduler;

  localparam int PKT_LEN = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [63:0] cfg_packets_per_burst = '0;
  logic [31:0] cfg_burst_count = '0;
  logic [31:0] cfg_gap_cycles = '0;
  logic        cmd_start = 1'b0;
  logic        cmd_stop = 1'b0;
  logic        gen_start;
  logic [63:0] gen_packet_count;
  logic        snoop_tvalid;
  logic        snoop_tready = 1'b1;
  logic        snoop_tlast;
  logic        busy;
  logic        done;
  logic        cfg_error;
  logic [31:0] bursts_done;
  logic [63:0] packets_sent;

  int n_chk = 0;
  int n_pass = 0;
  logic rand_rdy = 1'b0;

  always #5 clk = ~clk;

  ethgen_burst_scheduler dut (
    .clk                   (clk),
    .resetn                (resetn),
    .cfg_packets_per_burst (cfg_packets_per_burst),
    .cfg_burst_count       (cfg_burst_count),
    .cfg_gap_cycles        (cfg_gap_cycles),
    .cmd_start             (cmd_start),
    .cmd_stop              (cmd_stop),
    .gen_start             (gen_start),
    .gen_packet_count      (gen_packet_count),
    .snoop_tvalid          (snoop_tvalid),
    .snoop_tready          (snoop_tready),
    .snoop_tlast           (snoop_tlast),
    .busy                  (busy),
    .done                  (done),
    .cfg_error             (cfg_error),
    .bursts_done           (bursts_done),
    .packets_sent          (packets_sent)
  );

  // ---------------- behavioural generator ----------------
  logic [63:0] g_pkts_left;
  int          g_beat;
  int          g_dly;
  logic [63:0] g_n;
  logic        g_hs;

  assign snoop_tvalid = (g_pkts_left != 64'd0);
  assign snoop_tlast  = snoop_tvalid && (g_beat == PKT_LEN - 1);
  assign g_hs         = snoop_tvalid && snoop_tready;

  // Generator model: synchronous reset, 2-cycle start latency, AXIS-compliant hold.
  always @(posedge clk) begin
    if (!resetn) begin
      g_pkts_left <= '0;
      g_beat      <= 0;
      g_dly       <= 0;
      g_n         <= '0;
    end else begin
      if (g_hs) begin
        if (g_beat == PKT_LEN - 1) begin
          g_beat      <= 0;
          g_pkts_left <= g_pkts_left - 64'd1;
        end else begin
          g_beat <= g_beat + 1;
        end
      end
      if (g_dly > 0) g_dly <= g_dly - 1;
      if (g_dly == 1) g_pkts_left <= g_n;
      if (gen_start) begin
        if (gen_packet_count == 64'd0) begin
          g_dly       <= 0;
          g_pkts_left <= (snoop_tvalid && !(snoop_tlast && snoop_tready)) ? 64'd1 : 64'd0;
        end else begin
          g_dly <= 2;
          g_n   <= gen_packet_count;
        end
      end
    end
  end

  // ---------------- event monitor ----------------
  int          cyc = 0;
  int          n_pe = 0;
  int          n_done = 0;
  int          pe_cyc[$];
  int          gs_cyc[$];
  logic [63:0] gs_val[$];

  // Log packet ends, generator starts and done pulses mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (snoop_tvalid && snoop_tready && snoop_tlast) begin
      n_pe = n_pe + 1;
      pe_cyc.push_back(cyc);
    end
    if (gen_start) begin
      gs_cyc.push_back(cyc);
      gs_val.push_back(gen_packet_count);
    end
    if (done) n_done = n_done + 1;
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) snoop_tready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic start_run(input logic [63:0] ppb, input logic [31:0] bc, input logic [31:0] gap);
    cfg_packets_per_burst = ppb;
    cfg_burst_count       = bc;
    cfg_gap_cycles        = gap;
    cmd_start             = 1'b1;
    step();
    cmd_start             = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    while (!done && k < budget) begin
      step();
      k++;
    end
    n_chk++;
    if (done !== 1'b1) $display("FAIL %s: done not seen within %0d cycles", name, budget);
    else n_pass++;
  endtask

  task automatic wait_pe(input int base, input int target, input int budget, input string name);
    int k;
    k = 0;
    while ((n_pe - base) < target && k < budget) begin
      step();
      k++;
    end
    n_chk++;
    if ((n_pe - base) < target) $display("FAIL %s: saw %0d packet ends, need %0d", name, n_pe - base, target);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (gen_start !== 1'b0) $display("FAIL rst_gen_start: got %b want 0", gen_start); else n_pass++;
    n_chk++; if (gen_packet_count !== 64'd0) $display("FAIL rst_gen_cnt: got %0d want 0", gen_packet_count); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    n_chk++; if (cfg_error !== 1'b0) $display("FAIL rst_cfg_error: got %b want 0", cfg_error); else n_pass++;
    n_chk++; if (bursts_done !== 32'd0) $display("FAIL rst_bursts: got %0d want 0", bursts_done); else n_pass++;
    n_chk++; if (packets_sent !== 64'd0) $display("FAIL rst_packets: got %0d want 0", packets_sent); else n_pass++;
    resetn = 1'b1;
    step();
  endtask

  task automatic test_bursts_with_gap();
    int gs0, pe0, d0, diff;
    gs0 = gs_cyc.size(); pe0 = pe_cyc.size(); d0 = n_done;
    start_run(64'd3, 32'd2, 32'd10);
    wait_done(400, "t1_done");
    n_chk++; if (busy !== 1'b0) $display("FAIL t1_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (packets_sent !== 64'd6) $display("FAIL t1_packets: got %0d want 6", packets_sent); else n_pass++;
    n_chk++; if (bursts_done !== 32'd2) $display("FAIL t1_bursts: got %0d want 2", bursts_done); else n_pass++;
    repeat (3) step();
    n_chk++; if (n_done - d0 !== 1) $display("FAIL t1_done_count: got %0d want 1", n_done - d0); else n_pass++;
    n_chk++; if (gs_cyc.size() - gs0 !== 2) $display("FAIL t1_gen_starts: got %0d want 2", gs_cyc.size() - gs0); else n_pass++;
    n_chk++;
    if (gs_val.size() < gs0 + 2) $display("FAIL t1_gen_counts: got %0d starts want 2", gs_val.size() - gs0);
    else if (gs_val[gs0] !== 64'd3 || gs_val[gs0+1] !== 64'd3)
      $display("FAIL t1_gen_counts: got %0d,%0d want 3,3", gs_val[gs0], gs_val[gs0+1]);
    else n_pass++;
    // Burst-ending TLAST cycle, 10 GAP cycles, then the LAUNCH cycle: 11 apart.
    n_chk++;
    if (gs_cyc.size() < gs0 + 2 || pe_cyc.size() < pe0 + 3) $display("FAIL t1_gap: events missing");
    else begin
      diff = gs_cyc[gs0+1] - pe_cyc[pe0+2];
      if (diff !== 11) $display("FAIL t1_gap: got %0d cycles want 11", diff);
      else n_pass++;
    end
  endtask

  task automatic test_infinite_stop();
    int gs0, pe0, d0, nz, seen;
    gs0 = gs_cyc.size(); pe0 = n_pe; d0 = n_done;
    start_run(64'd1, 32'd0, 32'd0);
    wait_pe(pe0, 5, 200, "t2_five_packets");
    cmd_stop = 1'b1;
    step();
    cmd_stop = 1'b0;
    wait_done(100, "t2_done");
    repeat (4) step();
    seen = n_pe - pe0;
    nz = 0;
    for (int i = gs0; i < gs_val.size(); i++) if (gs_val[i] == 64'd0) nz++;
    n_chk++; if (nz !== 1) $display("FAIL t2_stop_start: got %0d zero-count starts want 1", nz); else n_pass++;
    n_chk++; if (seen < 5 || seen > 6) $display("FAIL t2_seen: got %0d want 5..6", seen); else n_pass++;
    n_chk++; if (packets_sent !== 64'(seen)) $display("FAIL t2_packets: got %0d want %0d", packets_sent, seen); else n_pass++;
    n_chk++; if (bursts_done !== 32'(seen)) $display("FAIL t2_bursts: got %0d want %0d", bursts_done, seen); else n_pass++;
    n_chk++; if (n_done - d0 !== 1) $display("FAIL t2_done_count: got %0d want 1", n_done - d0); else n_pass++;
    n_chk++; if (snoop_tvalid !== 1'b0) $display("FAIL t2_gen_idle: tvalid got %b want 0", snoop_tvalid); else n_pass++;
  endtask

  task automatic test_cfg_error();
    int gs0;
    gs0 = gs_cyc.size();
    cfg_packets_per_burst = 64'd2;
    cmd_start = 1'b1;
    cmd_stop  = 1'b1;
    step();
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    n_chk++; if (busy !== 1'b0) $display("FAIL t3_start_stop_busy: got %b want 0", busy); else n_pass++;
    start_run(64'd0, 32'd1, 32'd0);
    n_chk++; if (cfg_error !== 1'b1) $display("FAIL t3_cfg_error_set: got %b want 1", cfg_error); else n_pass++;
    repeat (5) step();
    n_chk++; if (busy !== 1'b0) $display("FAIL t3_busy_idle: got %b want 0", busy); else n_pass++;
    n_chk++; if (gs_cyc.size() - gs0 !== 0) $display("FAIL t3_no_start: got %0d starts want 0", gs_cyc.size() - gs0); else n_pass++;
    start_run(64'd2, 32'd1, 32'd0);
    n_chk++; if (cfg_error !== 1'b0) $display("FAIL t3_cfg_error_clr: got %b want 0", cfg_error); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL t3_busy_run: got %b want 1", busy); else n_pass++;
    wait_done(200, "t3_done");
    n_chk++; if (packets_sent !== 64'd2) $display("FAIL t3_packets: got %0d want 2", packets_sent); else n_pass++;
    n_chk++; if (bursts_done !== 32'd1) $display("FAIL t3_bursts: got %0d want 1", bursts_done); else n_pass++;
    step();
  endtask

  task automatic test_stop_in_gap();
    int gs0, pe0, nz;
    gs0 = gs_cyc.size(); pe0 = n_pe;
    start_run(64'd1, 32'd5, 32'd100);
    wait_pe(pe0, 1, 100, "t4_first_packet");
    repeat (3) step();
    n_chk++; if (busy !== 1'b1) $display("FAIL t4_busy_gap: got %b want 1", busy); else n_pass++;
    cmd_stop = 1'b1;
    step();
    cmd_stop = 1'b0;
    n_chk++; if (done !== 1'b1) $display("FAIL t4_done: got %b want 1", done); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL t4_busy: got %b want 0", busy); else n_pass++;
    repeat (3) step();
    nz = 0;
    for (int i = gs0; i < gs_val.size(); i++) if (gs_val[i] == 64'd0) nz++;
    n_chk++; if (nz !== 0) $display("FAIL t4_no_stop_start: got %0d zero-count starts want 0", nz); else n_pass++;
    n_chk++; if (gs_cyc.size() - gs0 !== 1) $display("FAIL t4_gen_starts: got %0d want 1", gs_cyc.size() - gs0); else n_pass++;
    n_chk++; if (packets_sent !== 64'd1) $display("FAIL t4_packets: got %0d want 1", packets_sent); else n_pass++;
    n_chk++; if (bursts_done !== 32'd1) $display("FAIL t4_bursts: got %0d want 1", bursts_done); else n_pass++;
  endtask

  task automatic test_random_ready();
    int gs0, d0, bad;
    gs0 = gs_cyc.size(); d0 = n_done;
    rand_rdy = 1'b1;
    start_run(64'd4, 32'd3, 32'd2);
    cfg_packets_per_burst = 64'd9;
    for (int p = 0; p < 3; p++) begin
      repeat (3) step();
      cmd_start = 1'b1;
      step();
      cmd_start = 1'b0;
    end
    wait_done(2000, "t5_done");
    rand_rdy = 1'b0;
    snoop_tready = 1'b1;
    n_chk++; if (packets_sent !== 64'd12) $display("FAIL t5_packets: got %0d want 12", packets_sent); else n_pass++;
    n_chk++; if (bursts_done !== 32'd3) $display("FAIL t5_bursts: got %0d want 3", bursts_done); else n_pass++;
    repeat (3) step();
    n_chk++; if (gs_cyc.size() - gs0 !== 3) $display("FAIL t5_gen_starts: got %0d want 3", gs_cyc.size() - gs0); else n_pass++;
    bad = 0;
    for (int i = gs0; i < gs_val.size(); i++) if (gs_val[i] != 64'd4) bad++;
    n_chk++; if (bad !== 0) $display("FAIL t5_gen_counts: got %0d starts with count other than 4, want 0", bad); else n_pass++;
    n_chk++; if (n_done - d0 !== 1) $display("FAIL t5_done_count: got %0d want 1", n_done - d0); else n_pass++;
  endtask

  task automatic test_async_reset();
    int pe0;
    pe0 = n_pe;
    start_run(64'd3, 32'd1, 32'd0);
    wait_pe(pe0, 1, 100, "t6_first_packet");
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL t6_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (gen_packet_count !== 64'd0) $display("FAIL t6_gen_cnt: got %0d want 0", gen_packet_count); else n_pass++;
    n_chk++; if (packets_sent !== 64'd0) $display("FAIL t6_packets: got %0d want 0", packets_sent); else n_pass++;
    n_chk++; if ({gen_start, done, cfg_error, bursts_done} !== 35'd0)
      $display("FAIL t6_misc: got %b/%b/%b/%0d want all 0", gen_start, done, cfg_error, bursts_done); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    step();
    start_run(64'd2, 32'd2, 32'd1);
    wait_done(300, "t6_done");
    n_chk++; if (packets_sent !== 64'd4) $display("FAIL t6_rerun_packets: got %0d want 4", packets_sent); else n_pass++;
    n_chk++; if (bursts_done !== 32'd2) $display("FAIL t6_rerun_bursts: got %0d want 2", bursts_done); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bursts_with_gap();
    test_infinite_stop();
    test_cfg_error();
    test_stop_in_gap();
    test_random_ready();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
